// File: rtl/note_pkg.sv
// Shared constants, helpers and FSM encoding for the note_player tone synthesizer.
package note_pkg;

  localparam logic [11:0] C       = 12'h800;
  localparam logic [11:0] Cs      = 12'h400;
  localparam logic [11:0] D       = 12'h200;
  localparam logic [11:0] Ds      = 12'h100;
  localparam logic [11:0] E       = 12'h080;
  localparam logic [11:0] F       = 12'h040;
  localparam logic [11:0] Fs      = 12'h020;
  localparam logic [11:0] G       = 12'h010;
  localparam logic [11:0] Gs      = 12'h008;
  localparam logic [11:0] A       = 12'h004;
  localparam logic [11:0] As      = 12'h002;
  localparam logic [11:0] B       = 12'h001;
  localparam logic [11:0] no_note = 12'h000;

  localparam logic [11:0] Df = Cs;
  localparam logic [11:0] Ef = Ds;
  localparam logic [11:0] Gf = Fs;
  localparam logic [11:0] Af = Gs;
  localparam logic [11:0] Bf = As;

  // Base-octave (C4..B4) frequencies in units of 0.01 Hz.
  localparam int unsigned freq_100_c  = 26163;
  localparam int unsigned freq_100_cs = 27718;
  localparam int unsigned freq_100_d  = 29366;
  localparam int unsigned freq_100_ds = 31113;
  localparam int unsigned freq_100_e  = 32963;
  localparam int unsigned freq_100_f  = 34923;
  localparam int unsigned freq_100_fs = 36999;
  localparam int unsigned freq_100_g  = 39200;
  localparam int unsigned freq_100_gs = 41530;
  localparam int unsigned freq_100_a  = 44000;
  localparam int unsigned freq_100_as = 46616;
  localparam int unsigned freq_100_b  = 49388;

  localparam logic [3:0] idx_invalid = 4'hf;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_t;

  function automatic logic [17:0] half_period(input int unsigned freq_100,
                                              input int unsigned clk_mhz);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clk_mhz) * 64'd100000000;
    den = 64'(freq_100) * 64'd2;
    return 18'(num / den);
  endfunction

  // C (bit 11) maps to index 0, B (bit 0) to index 11; zero or multi-hot is invalid.
  function automatic logic [3:0] onehot_to_idx(input logic [11:0] code);
    logic [3:0]  idx;
    int unsigned ones;
    idx  = idx_invalid;
    ones = 0;
    for (int i = 0; i < 12; i++) begin
      if (code[i]) begin
        ones++;
        idx = 4'(11 - i);
      end
    end
    return (ones == 1) ? idx : idx_invalid;
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Note request channel: valid/ready handshake carrying note, octave and duration.
interface note_player_if #(
  parameter int unsigned w_dur = 16
);
  logic             note_valid;
  logic             note_ready;
  logic [11:0]      note;
  logic [1:0]       octave;
  logic [w_dur-1:0] dur_ms;

  modport master (output note_valid, note, octave, dur_ms, input note_ready);
  modport slave  (input note_valid, note, octave, dur_ms, output note_ready);
endinterface

// File: rtl/ms_strobe.sv
// Millisecond prescaler: one-cycle tick every clk_mhz*1000 cycles, restartable.
module ms_strobe #(
  parameter int unsigned clk_mhz = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int unsigned Ticks = clk_mhz * 1000;
  localparam int unsigned Cw    = $clog2(Ticks);

  logic [Cw-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == '0)) begin
      cnt_q <= Cw'(Ticks - 1);
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick = (cnt_q == '0);
endmodule

// File: rtl/note_player.sv
// Square-wave note synthesizer: accepts a note request, plays it, then inserts a silent gap.
module note_player
  import note_pkg::*;
#(
  parameter int unsigned clk_mhz   = 50,
  parameter int unsigned w_dur     = 16,
  parameter logic [15:0] amplitude = 16'h2000,
  parameter int unsigned gap_ms    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  note_player_if.slave        req,
  output logic                busy,
  output logic [11:0]         cur_note,
  output logic [15:0]         sound
);
  localparam logic [w_dur-1:0] GapCount = w_dur'(gap_ms);

  // Padded to 16 entries so the invalid index reads a harmless zero.
  localparam logic [17:0] PeriodTable [16] = '{
    half_period(freq_100_c,  clk_mhz), half_period(freq_100_cs, clk_mhz),
    half_period(freq_100_d,  clk_mhz), half_period(freq_100_ds, clk_mhz),
    half_period(freq_100_e,  clk_mhz), half_period(freq_100_f,  clk_mhz),
    half_period(freq_100_fs, clk_mhz), half_period(freq_100_g,  clk_mhz),
    half_period(freq_100_gs, clk_mhz), half_period(freq_100_a,  clk_mhz),
    half_period(freq_100_as, clk_mhz), half_period(freq_100_b,  clk_mhz),
    18'd0, 18'd0, 18'd0, 18'd0
  };

  state_t           state_q;
  logic [11:0]      note_q;
  logic             rest_q;
  logic             pol_q;
  logic [17:0]      half_q;
  logic [17:0]      phase_q;
  logic [w_dur-1:0] remain_q;
  logic [11:0]      cur_note_q;
  logic [15:0]      sound_q;

  logic        tick;
  logic        accept;
  logic        play_done;
  logic        restart;
  logic [3:0]  idx_in;
  logic [17:0] half_in;

  assign idx_in         = onehot_to_idx(req.note);
  assign half_in        = PeriodTable[idx_in] >> req.octave;
  assign req.note_ready = (state_q == StIdle);
  assign busy           = ~req.note_ready;
  assign accept         = req.note_valid & req.note_ready;
  assign play_done      = (state_q == StPlay) & tick & (remain_q <= w_dur'(1));
  assign restart        = accept | play_done;

  ms_strobe #(
    .clk_mhz(clk_mhz)
  ) u_ms_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      note_q     <= '0;
      rest_q     <= 1'b0;
      pol_q      <= 1'b0;
      half_q     <= '0;
      phase_q    <= '0;
      remain_q   <= '0;
      cur_note_q <= '0;
      sound_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          sound_q    <= '0;
          cur_note_q <= '0;
          if (accept) begin
            note_q  <= req.note;
            rest_q  <= (idx_in == idx_invalid);
            half_q  <= half_in;
            phase_q <= half_in - 18'd1;
            pol_q   <= 1'b1;
            if (req.dur_ms == '0) begin
              state_q  <= StGap;
              remain_q <= GapCount;
            end else begin
              state_q  <= StPlay;
              remain_q <= req.dur_ms;
            end
          end
        end
        StPlay: begin
          sound_q    <= rest_q ? '0 : (pol_q ? amplitude : -amplitude);
          cur_note_q <= rest_q ? '0 : note_q;
          if (phase_q == '0) begin
            phase_q <= half_q - 18'd1;
            pol_q   <= ~pol_q;
          end else begin
            phase_q <= phase_q - 18'd1;
          end
          if (play_done) begin
            state_q  <= StGap;
            remain_q <= GapCount;
          end else if (tick) begin
            remain_q <= remain_q - w_dur'(1);
          end
        end
        StGap: begin
          sound_q    <= '0;
          cur_note_q <= '0;
          if (tick) begin
            remain_q <= remain_q - w_dur'(1);
            if (remain_q <= w_dur'(1)) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cur_note = cur_note_q;
  assign sound    = sound_q;
endmodule

// File: tb/tb_note_player.sv
// Randomized bench for note_player; expected outputs come from a cycles-since-accept model.
module tb_note_player;
  localparam int unsigned ClkMhz = 1;
  localparam int unsigned GapMs  = 1;
  localparam int          T      = ClkMhz * 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        busy;
  logic [11:0] cur_note;
  logic [15:0] sound;

  note_player_if #(.w_dur(16)) req_if ();

  note_player #(
    .clk_mhz  (ClkMhz),
    .w_dur    (16),
    .amplitude(16'h2000),
    .gap_ms   (GapMs)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_if),
    .busy    (busy),
    .cur_note(cur_note),
    .sound   (sound)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int freq_tab [12] = '{26163, 27718, 29366, 31113, 32963, 34923,
                        36999, 39200, 41530, 44000, 46616, 49388};

  // Model: request in flight, cycles since its accept edge, captured fields.
  bit          busy_m   = 1'b0;
  int          m        = 0;
  int          cap_dur  = 0;
  int          cap_half = 0;
  logic [11:0] cap_note = '0;
  bit          accepted = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Toggle half-period in cycles; 0 means the code is a rest.
  function automatic int model_half(input logic [11:0] n, input logic [1:0] oct);
    int     hits = 0;
    int     idx  = 0;
    longint hp;
    for (int i = 0; i < 12; i++) begin
      if (n[11 - i]) begin
        hits++;
        idx = i;
      end
    end
    if (hits != 1) return 0;
    hp = (longint'(ClkMhz) * 100000000) / (longint'(freq_tab[idx]) * 2);
    return int'(hp) >> oct;
  endfunction

  task automatic check_outputs();
    logic [15:0] es;
    logic [11:0] en;
    bit          in_play;
    in_play = (m >= 1) && (m <= cap_dur * T);
    es = '0;
    en = '0;
    if (in_play && cap_half != 0) begin
      en = cap_note;
      es = ((((m - 1) / cap_half) % 2) == 0) ? 16'h2000 : 16'he000;
    end
    check("note_ready", {31'd0, req_if.note_ready}, {31'd0, !busy_m});
    check("busy", {31'd0, busy}, {31'd0, busy_m});
    check("cur_note", {20'd0, cur_note}, {20'd0, en});
    check("sound", {16'd0, sound}, {16'd0, es});
  endtask

  task automatic step();
    @(posedge clk);
    accepted = 1'b0;
    if (!rst_n) begin
      busy_m  = 1'b0;
      m       = 0;
      cap_dur = 0;
    end else if (!busy_m) begin
      if (req_if.note_valid) begin
        cap_note = req_if.note;
        cap_half = model_half(req_if.note, req_if.octave);
        cap_dur  = int'(req_if.dur_ms);
        busy_m   = 1'b1;
        m        = 0;
        accepted = 1'b1;
      end
    end else begin
      m++;
      if (m == (cap_dur + GapMs) * T) busy_m = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Present a request and hold it until accepted; afterwards scramble the bus with valid low.
  task automatic play(input logic [11:0] n, input logic [1:0] oct, input int dur);
    int waited = 0;
    req_if.note_valid = 1'b1;
    req_if.note       = n;
    req_if.octave     = oct;
    req_if.dur_ms     = 16'(dur);
    accepted          = 1'b0;
    while (!accepted && waited < 20000) begin
      step();
      waited++;
    end
    req_if.note_valid = 1'b0;
    req_if.note       = 12'($urandom);
    req_if.octave     = 2'($urandom);
    req_if.dur_ms     = 16'($urandom);
  endtask

  task automatic drain();
    int waited = 0;
    req_if.note_valid = 1'b0;
    while (busy_m && waited < 20000) begin
      step();
      waited++;
    end
    repeat (3) step();
  endtask

  initial begin
    logic [11:0] rn;
    int          r;
    req_if.note_valid = 1'b0;
    req_if.note       = '0;
    req_if.octave     = '0;
    req_if.dur_ms     = '0;

    #1 rst_n = 1'b0;
    #1 check_outputs();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Second request is held valid while the first plays.
    play(12'h004, 2'd0, 2);
    play(12'h004, 2'd1, 1);
    play(12'h000, 2'd0, 1);
    play(12'h005, 2'd2, 1);
    play(12'h800, 2'd3, 0);
    drain();

    play(12'h004, 2'd0, 2);
    repeat (700) step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_sound", {16'd0, sound}, 32'd0);
    check("rst_ready", {31'd0, req_if.note_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cur_note", {20'd0, cur_note}, 32'd0);
    busy_m  = 1'b0;
    m       = 0;
    cap_dur = 0;
    repeat (2) step();
    rst_n = 1'b1;
    play(12'h080, 2'd1, 1);
    drain();

    for (int k = 0; k < 8; k++) begin
      r = int'($urandom_range(0, 15));
      if (r < 12) rn = 12'h800 >> r;
      else if (r == 12) rn = 12'h000;
      else rn = 12'($urandom) | 12'h003;
      play(rn, 2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
